// File: rtl/pipe_stage_reg_pkg.sv
// Shared Y86 constants for the pipeline stage registers: instruction codes,
// register IDs, bubble-state field values and the per-edge stage action.
package pipe_stage_reg_pkg;

    // Y86 instruction codes.
    localparam logic [7:0] Y86_IHALT   = 8'h0;
    localparam logic [7:0] Y86_INOP    = 8'h1;
    localparam logic [7:0] Y86_IRRMOVL = 8'h2;
    localparam logic [7:0] Y86_IIRMOVL = 8'h3;
    localparam logic [7:0] Y86_IRMMOVL = 8'h4;
    localparam logic [7:0] Y86_IMRMOVL = 8'h5;
    localparam logic [7:0] Y86_IOPL    = 8'h6;
    localparam logic [7:0] Y86_IJXX    = 8'h7;
    localparam logic [7:0] Y86_ICALL   = 8'h8;
    localparam logic [7:0] Y86_IRET    = 8'h9;
    localparam logic [7:0] Y86_IPUSHL  = 8'hA;
    localparam logic [7:0] Y86_IPOPL   = 8'hB;

    // Y86 register IDs; RNONE marks "no register".
    localparam logic [7:0] Y86_REAX  = 8'h0;
    localparam logic [7:0] Y86_RECX  = 8'h1;
    localparam logic [7:0] Y86_REDX  = 8'h2;
    localparam logic [7:0] Y86_REBX  = 8'h3;
    localparam logic [7:0] Y86_RESP  = 8'h4;
    localparam logic [7:0] Y86_REBP  = 8'h5;
    localparam logic [7:0] Y86_RESI  = 8'h6;
    localparam logic [7:0] Y86_REDI  = 8'h7;
    localparam logic [7:0] Y86_RNONE = 8'hF;

    // Bubble-state values for the fields that do not come from parameters.
    localparam logic [7:0]  BUBBLE_IFUN = 8'h0;
    localparam logic [31:0] BUBBLE_VAL  = 32'h0;

    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_STALL  = 2'd1,
        ACT_BUBBLE = 2'd2
    } stage_action_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear has priority) and
// increment enable; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Y86 inter-stage pipeline register with load / stall / bubble control,
// slot validity and a stall+bubble conflict flag. Perf counters under PIPE_PERF_EN.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                BYTE_W    = 8,
    parameter int                WORD_W    = 32,
    parameter logic [BYTE_W-1:0] NOP_ICODE = BYTE_W'(Y86_INOP),
    parameter logic [BYTE_W-1:0] RNONE     = BYTE_W'(Y86_RNONE),
    parameter int                CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              bubble_i,
    input  logic [BYTE_W-1:0] in_icode_i,
    input  logic [BYTE_W-1:0] in_ifun_i,
    input  logic [BYTE_W-1:0] in_rA_i,
    input  logic [BYTE_W-1:0] in_rB_i,
    input  logic [BYTE_W-1:0] in_dstE_i,
    input  logic [BYTE_W-1:0] in_dstM_i,
    input  logic [WORD_W-1:0] in_valC_i,
    input  logic [WORD_W-1:0] in_valP_i,
    output logic [BYTE_W-1:0] out_icode_o,
    output logic [BYTE_W-1:0] out_ifun_o,
    output logic [BYTE_W-1:0] out_rA_o,
    output logic [BYTE_W-1:0] out_rB_o,
    output logic [BYTE_W-1:0] out_dstE_o,
    output logic [BYTE_W-1:0] out_dstM_o,
    output logic [WORD_W-1:0] out_valC_o,
    output logic [WORD_W-1:0] out_valP_o,
`ifdef PIPE_PERF_EN
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o,
`endif
    output logic              valid_o,
    output logic              conflict_o
);

    typedef struct packed {
        logic [BYTE_W-1:0] icode;
        logic [BYTE_W-1:0] ifun;
        logic [BYTE_W-1:0] rA;
        logic [BYTE_W-1:0] rB;
        logic [BYTE_W-1:0] dstE;
        logic [BYTE_W-1:0] dstM;
        logic [WORD_W-1:0] valC;
        logic [WORD_W-1:0] valP;
    } stage_fields_t;

    localparam stage_fields_t BUBBLE_FIELDS = '{
        icode: NOP_ICODE,
        ifun:  BYTE_W'(BUBBLE_IFUN),
        rA:    RNONE,
        rB:    RNONE,
        dstE:  RNONE,
        dstM:  RNONE,
        valC:  WORD_W'(BUBBLE_VAL),
        valP:  WORD_W'(BUBBLE_VAL)
    };

    stage_action_e action;
    stage_fields_t fields_d, fields_q;
    logic          valid_d, valid_q;
    logic          conflict_d, conflict_q;

    // Bubble outranks stall so a squashed instruction can never be held.
    always_comb begin
        action = ACT_LOAD;
        if (bubble_i) begin
            action = ACT_BUBBLE;
        end else if (stall_i) begin
            action = ACT_STALL;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred on any path.
    always_comb begin
        fields_d   = fields_q;
        valid_d    = valid_q;
        conflict_d = stall_i & bubble_i;
        case (action)
            ACT_BUBBLE: begin
                fields_d = BUBBLE_FIELDS;
                valid_d  = 1'b0;
            end
            ACT_LOAD: begin
                fields_d = '{
                    icode: in_icode_i,
                    ifun:  in_ifun_i,
                    rA:    in_rA_i,
                    rB:    in_rB_i,
                    dstE:  in_dstE_i,
                    dstM:  in_dstM_i,
                    valC:  in_valC_i,
                    valP:  in_valP_i
                };
                valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fields_q   <= BUBBLE_FIELDS;
            valid_q    <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            fields_q   <= fields_d;
            valid_q    <= valid_d;
            conflict_q <= conflict_d;
        end
    end

    assign out_icode_o = fields_q.icode;
    assign out_ifun_o  = fields_q.ifun;
    assign out_rA_o    = fields_q.rA;
    assign out_rB_o    = fields_q.rB;
    assign out_dstE_o  = fields_q.dstE;
    assign out_dstM_o  = fields_q.dstM;
    assign out_valC_o  = fields_q.valC;
    assign out_valP_o  = fields_q.valP;
    assign valid_o     = valid_q;
    assign conflict_o  = conflict_q;

`ifdef PIPE_PERF_EN
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr_i (rst),
        .inc_i (action == ACT_STALL),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .clr_i (rst),
        .inc_i (action == ACT_BUBBLE),
        .cnt_o (bubble_cnt_o)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (CNT_W=4 so saturation is
// reachable); counter checks are compiled in only when PIPE_PERF_EN is defined.
module tb_pipe_stage_reg;

    localparam int FW = 6 * 8 + 2 * 32;

    logic clk = 1'b0;
    logic rst, stall_i, bubble_i;
    logic [7:0]  in_icode, in_ifun, in_ra, in_rb, in_dste, in_dstm;
    logic [31:0] in_valc, in_valp;
    logic [7:0]  out_icode, out_ifun, out_ra, out_rb, out_dste, out_dstm;
    logic [31:0] out_valc, out_valp;
    logic        valid_o, conflict_o;
`ifdef PIPE_PERF_EN
    logic [3:0]  stall_cnt, bubble_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [FW-1:0] out_bus;
    assign out_bus = {out_icode, out_ifun, out_ra, out_rb, out_dste, out_dstm, out_valc, out_valp};

    localparam logic [FW-1:0] BUBBLE_BUS = {8'h1, 8'h0, 8'hF, 8'hF, 8'hF, 8'hF, 32'h0, 32'h0};

    always #5 clk = ~clk;

    pipe_stage_reg #(.CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_i     (stall_i),
        .bubble_i    (bubble_i),
        .in_icode_i  (in_icode),
        .in_ifun_i   (in_ifun),
        .in_rA_i     (in_ra),
        .in_rB_i     (in_rb),
        .in_dstE_i   (in_dste),
        .in_dstM_i   (in_dstm),
        .in_valC_i   (in_valc),
        .in_valP_i   (in_valp),
        .out_icode_o (out_icode),
        .out_ifun_o  (out_ifun),
        .out_rA_o    (out_ra),
        .out_rB_o    (out_rb),
        .out_dstE_o  (out_dste),
        .out_dstM_o  (out_dstm),
        .out_valC_o  (out_valc),
        .out_valP_o  (out_valp),
`ifdef PIPE_PERF_EN
        .stall_cnt_o (stall_cnt),
        .bubble_cnt_o(bubble_cnt),
`endif
        .valid_o     (valid_o),
        .conflict_o  (conflict_o)
    );

    // Drive a whole input bundle given as the same concatenation as out_bus.
    task automatic set_in(input logic [FW-1:0] v);
        {in_icode, in_ifun, in_ra, in_rb, in_dste, in_dstm, in_valc, in_valp} = v;
    endtask

    // Advance one edge and settle 1 time unit past it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bus(input string name, input logic [FW-1:0] exp);
        checks++;
        if (out_bus !== exp) begin
            failures++;
            $display("FAIL %s: fields got %h expected %h", name, out_bus, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

`ifdef PIPE_PERF_EN
    task automatic check_cnt(input string name, input logic [3:0] exp_stall, input logic [3:0] exp_bubble);
        checks++;
        if (stall_cnt !== exp_stall || bubble_cnt !== exp_bubble) begin
            failures++;
            $display("FAIL %s: stall_cnt=%h bubble_cnt=%h expected %h %h",
                     name, stall_cnt, bubble_cnt, exp_stall, exp_bubble);
        end
    endtask
`endif

    task automatic test_reset();
        rst = 1'b1; stall_i = 1'b1; bubble_i = 1'b1;
        set_in({8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h77, 8'h88, 32'hFFFF_0000, 32'h1234_5678});
        step();
        step();
        check_bus("reset_fields", BUBBLE_BUS);
        check_bit("reset_valid", valid_o, 1'b0);
        check_bit("reset_conflict", conflict_o, 1'b0);
`ifdef PIPE_PERF_EN
        check_cnt("reset_counters", 4'h0, 4'h0);
`endif
        rst = 1'b0; stall_i = 1'b0; bubble_i = 1'b0;
    endtask

    task automatic test_pass_through();
        set_in({8'h3, 8'h0, 8'hF, 8'h2, 8'h2, 8'hF, 32'h1234, 32'h6});
        step();
        check_bus("pass_irmovl", {8'h3, 8'h0, 8'hF, 8'h2, 8'h2, 8'hF, 32'h1234, 32'h6});
        check_bit("pass_valid", valid_o, 1'b1);
        check_bit("pass_conflict", conflict_o, 1'b0);
        set_in({8'h6, 8'h1, 8'h0, 8'h3, 8'h3, 8'hF, 32'hDEAD_BEEF, 32'h2A});
        step();
        check_bus("pass_opl", {8'h6, 8'h1, 8'h0, 8'h3, 8'h3, 8'hF, 32'hDEAD_BEEF, 32'h2A});
        // A real icode of NOP still counts as a valid slot.
        set_in({8'h1, 8'h0, 8'hF, 8'hF, 8'hF, 8'hF, 32'h0, 32'h2B});
        step();
        check_bit("pass_nop_valid", valid_o, 1'b1);
    endtask

    task automatic test_stall();
        logic [FW-1:0] held;
        logic [FW-1:0] fresh;
        held  = {8'h5, 8'h0, 8'h4, 8'h1, 8'hF, 8'h1, 32'h10, 32'h30};
        fresh = {8'h2, 8'h0, 8'h1, 8'h7, 8'h7, 8'hF, 32'h0, 32'h32};
        set_in(held);
        step();
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in({8'h9 + 8'(i), 8'h0, 8'h4, 8'h4, 8'h4, 8'hF, 32'(i) + 32'h100, 32'h40});
            step();
            check_bus($sformatf("stall_hold_%0d", i), held);
        end
        check_bit("stall_valid", valid_o, 1'b1);
`ifdef PIPE_PERF_EN
        check_cnt("stall_count", 4'h3, 4'h0);
`endif
        stall_i = 1'b0;
        set_in(fresh);
        step();
        check_bus("stall_release_loads_live", fresh);
`ifdef PIPE_PERF_EN
        check_cnt("stall_release_count", 4'h3, 4'h0);
`endif
    endtask

    task automatic test_bubble();
        logic [FW-1:0] live;
        live = {8'h7, 8'h3, 8'hF, 8'hF, 8'hF, 8'hF, 32'h200, 32'h45};
        set_in({8'hB, 8'h0, 8'h4, 8'hF, 8'h4, 8'h0, 32'h0, 32'h44});
        bubble_i = 1'b1;
        step();
        check_bus("bubble_fields", BUBBLE_BUS);
        check_bit("bubble_valid", valid_o, 1'b0);
        check_bit("bubble_conflict", conflict_o, 1'b0);
`ifdef PIPE_PERF_EN
        check_cnt("bubble_count", 4'h3, 4'h1);
`endif
        bubble_i = 1'b0;
        set_in(live);
        step();
        check_bus("after_bubble_loads", live);
        check_bit("after_bubble_valid", valid_o, 1'b1);
    endtask

    task automatic test_conflict();
        logic [FW-1:0] live;
        live = {8'h8, 8'h0, 8'hF, 8'hF, 8'h4, 8'hF, 32'h300, 32'h50};
        set_in({8'h4, 8'h0, 8'h0, 8'h5, 8'hF, 8'hF, 32'h8, 32'h4A});
        stall_i = 1'b1; bubble_i = 1'b1;
        step();
        check_bus("conflict_bubble_wins", BUBBLE_BUS);
        check_bit("conflict_valid", valid_o, 1'b0);
        check_bit("conflict_flag_set", conflict_o, 1'b1);
`ifdef PIPE_PERF_EN
        check_cnt("conflict_count", 4'h3, 4'h2);
`endif
        stall_i = 1'b0; bubble_i = 1'b0;
        set_in(live);
        step();
        check_bit("conflict_flag_clears", conflict_o, 1'b0);
        check_bus("after_conflict_loads", live);
    endtask

    task automatic test_saturation_reset_mid_stall();
        logic [FW-1:0] held;
        held = {8'h8, 8'h0, 8'hF, 8'hF, 8'h4, 8'hF, 32'h300, 32'h50};
        stall_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_in({8'(i), 8'h1, 8'h2, 8'h3, 8'h4, 8'h5, 32'(i), 32'(i * 3)});
            step();
        end
        check_bus("long_stall_hold", held);
`ifdef PIPE_PERF_EN
        check_cnt("stall_saturated", 4'hF, 4'h2);
`endif
        rst = 1'b1;
        step();
        check_bus("reset_mid_stall_fields", BUBBLE_BUS);
        check_bit("reset_mid_stall_valid", valid_o, 1'b0);
`ifdef PIPE_PERF_EN
        check_cnt("reset_mid_stall_counters", 4'h0, 4'h0);
`endif
        // Stall still asserted after reset: the bubble state is held.
        rst = 1'b0;
        step();
        check_bus("post_reset_stall_hold", BUBBLE_BUS);
        check_bit("post_reset_stall_valid", valid_o, 1'b0);
`ifdef PIPE_PERF_EN
        check_cnt("post_reset_stall_count", 4'h1, 4'h0);
`endif
        stall_i = 1'b0;
        set_in({8'h9, 8'h0, 8'h4, 8'hF, 8'h4, 8'hF, 32'h0, 32'h60});
        step();
        check_bus("post_reset_load", {8'h9, 8'h0, 8'h4, 8'hF, 8'h4, 8'hF, 32'h0, 32'h60});
        check_bit("post_reset_load_valid", valid_o, 1'b1);
    endtask

    initial begin
        rst = 1'b1; stall_i = 1'b0; bubble_i = 1'b0;
        set_in('0);
        #2;
        test_reset();
        test_pass_through();
        test_stall();
        test_bubble();
        test_conflict();
        test_saturation_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
